// File: rtl/ras_redirect_ctrl_pkg.sv
// Shared frontend definitions: opcodes, RAS defaults, redirect FSM encoding.
package ras_redirect_ctrl_pkg;

  // RV32 major opcodes seen by the predecoder
  localparam logic [6:0] INST_BRANCH = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;

  localparam int unsigned RAS_DEPTH_DEFAULT = 8;

  // Link address is the instruction after the call
  localparam int unsigned LINK_INCR = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } redir_state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; entries are never cleared, only pointer/count.
module ras_stack #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_WIDTH-1:0]    push_data,
  output logic [ADDR_WIDTH-1:0]    top_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       ptr_q, ptr_d, wr_ptr;
  logic [CntW-1:0]       count_q, count_d;
  logic                  wr_en;
  logic                  pop_ok;

  assign pop_ok   = pop && (count_q != '0);
  assign top_data = mem[ptr_q];
  assign count    = count_q;

  // Next pointer/count; pop+push rewrites the current top in place
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_ptr  = ptr_q;
    if (clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push && pop_ok) begin
      wr_en = 1'b1;
    end else if (push) begin
      wr_ptr = ptr_q + 1'b1;
      ptr_d  = wr_ptr;
      wr_en  = 1'b1;
      if (count_q != Full) begin
        count_d = count_q + 1'b1;
      end
    end else if (pop_ok) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ras_redirect_ctrl.sv
// Predecode-stage redirect controller: picks fetch targets and drives the RAS.
module ras_redirect_ctrl
  import ras_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAS_DEPTH  = RAS_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  input  logic [ADDR_WIDTH-1:0]       inst_pc,
  input  logic                        pdec_branch,
  input  logic                        pdec_jal,
  input  logic                        pdec_jalr,
  input  logic                        pdec_call,
  input  logic                        pdec_ret,
  input  logic [ADDR_WIDTH-1:0]       pdec_pc,
  input  logic                        flush,
  output logic                        redir_valid,
  input  logic                        redir_ready,
  output logic [ADDR_WIDTH-1:0]       redir_pc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  redir_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] target;
  logic                  accept;
  logic                  do_pop, do_push;
  logic                  redir_hit;
  logic                  unused_jalr;

  // Indirect jumps that are not returns have no predictable target here
  assign unused_jalr = pdec_jalr;

  assign redir_valid = (state_q == StHold);
  assign inst_ready  = ~redir_valid;
  assign redir_pc    = redir_pc_q;
  assign accept      = inst_valid & inst_ready & ~flush;
  assign do_pop      = accept & pdec_ret & (ras_count != '0);
  assign do_push     = accept & pdec_call;

  // Target select: return beats jal beats backward branch
  always_comb begin
    redir_hit = 1'b0;
    target    = pdec_pc;
    if (pdec_ret && (ras_count != '0)) begin
      redir_hit = 1'b1;
      target    = ras_top;
    end else if (pdec_jal) begin
      redir_hit = 1'b1;
    end else if (pdec_branch && (pdec_pc < inst_pc)) begin
      redir_hit = 1'b1;
    end
  end

  // Redirect FSM next state; flush overrides everything
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && redir_hit) begin
            state_d    = StHold;
            redir_pc_d = target;
          end
        end
        StHold: begin
          if (redir_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and redirect target registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  ras_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (inst_pc + ADDR_WIDTH'(LINK_INCR)),
    .top_data  (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_ras_redirect_ctrl.sv
// Directed bench with a reference stack model and an expected-redirect queue.
module tb_ras_redirect_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_valid, inst_ready;
  logic [AW-1:0] inst_pc, pdec_pc, redir_pc;
  logic          pdec_branch, pdec_jal, pdec_jalr, pdec_call, pdec_ret;
  logic          flush, redir_valid, redir_ready;
  logic [3:0]    ras_count;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mstack [$];

  always #5 clk = ~clk;

  ras_redirect_ctrl #(
    .ADDR_WIDTH (AW),
    .RAS_DEPTH  (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_pc     (inst_pc),
    .pdec_branch (pdec_branch),
    .pdec_jal    (pdec_jal),
    .pdec_jalr   (pdec_jalr),
    .pdec_call   (pdec_call),
    .pdec_ret    (pdec_ret),
    .pdec_pc     (pdec_pc),
    .flush       (flush),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_pc    (redir_pc),
    .ras_count   (ras_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_valid  = 1'b0;
    pdec_branch = 1'b0;
    pdec_jal    = 1'b0;
    pdec_jalr   = 1'b0;
    pdec_call   = 1'b0;
    pdec_ret    = 1'b0;
    inst_pc     = '0;
    pdec_pc     = '0;
  endtask

  // Reference behaviour of one accepted instruction
  task automatic model(input logic [31:0] pc, input logic br, input logic jal,
                       input logic call, input logic ret, input logic [31:0] tgt,
                       output logic r, output logic [31:0] t);
    r = 1'b0;
    t = '0;
    if (ret && mstack.size() > 0) begin
      r = 1'b1;
      t = mstack.pop_back();
    end else if (jal) begin
      r = 1'b1;
      t = tgt;
    end else if (br && tgt < pc) begin
      r = 1'b1;
      t = tgt;
    end
    if (call) begin
      mstack.push_back(pc + 32'd4);
      if (mstack.size() > D) void'(mstack.pop_front());
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic br, input logic jal,
                       input logic jalr, input logic call, input logic ret,
                       input logic [31:0] tgt);
    inst_valid  = 1'b1;
    inst_pc     = pc;
    pdec_branch = br;
    pdec_jal    = jal;
    pdec_jalr   = jalr;
    pdec_call   = call;
    pdec_ret    = ret;
    pdec_pc     = tgt;
  endtask

  // One instruction through the controller, completing any redirect handshake
  task automatic send(input string tag, input logic [31:0] pc, input logic br,
                      input logic jal, input logic jalr, input logic call,
                      input logic ret, input logic [31:0] tgt);
    logic r;
    logic [31:0] t;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(inst_ready), 32'd1);
    drive(pc, br, jal, jalr, call, ret, tgt);
    model(pc, br, jal, call, ret, tgt, r, t);
    if (r) exp_q.push_back(t);
    @(negedge clk);
    idle_inputs();
    chk({tag, "_count"}, 32'(ras_count), 32'(mstack.size()));
    chk({tag, "_rvalid"}, 32'(redir_valid), 32'(r));
    if (redir_valid === 1'b1) begin
      chk({tag, "_qsize"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) chk({tag, "_rpc"}, redir_pc, exp_q.pop_front());
      chk({tag, "_busy"}, 32'(inst_ready), 32'd0);
      redir_ready = 1'b1;
      @(negedge clk);
      redir_ready = 1'b0;
      chk({tag, "_done"}, 32'(redir_valid), 32'd0);
    end
  endtask

  initial begin
    logic r;
    logic [31:0] t;
    idle_inputs();
    flush       = 1'b0;
    redir_ready = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(redir_valid), 32'd0);
    chk("rst_rpc", redir_pc, 32'd0);
    chk("rst_count", 32'(ras_count), 32'd0);
    chk("rst_ready", 32'(inst_ready), 32'd1);
    rst = 1'b0;

    // Jal redirect and handshake
    send("jal", 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h180);

    // Nested call/return
    send("call1", 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    send("call2", 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    send("ret1", 32'h400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    send("ret2", 32'h404, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    send("ret_empty", 32'h408, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);

    // Overflow wraps and keeps the newest eight
    for (int i = 0; i < 9; i++) begin
      send("ovf_call", 32'h1000 + 32'(16 * i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    for (int i = 0; i < 9; i++) begin
      send("ovf_ret", 32'h2000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    end

    // Branch direction
    send("br_back", 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F0);
    send("br_fwd", 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h410);
    chk("br_fwd_ready", 32'(inst_ready), 32'd1);
    send("jalr", 32'h420, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500);

    // Simultaneous call and return
    send("cr_call", 32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    send("cr_both", 32'h500, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    send("cr_ret", 32'h700, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);

    // Stalled redirect, instruction offered while busy, then flush
    send("hold_call", 32'h700, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(32'h800, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h880);
    model(32'h800, 1'b0, 1'b1, 1'b0, 1'b0, 32'h880, r, t);
    exp_q.push_back(t);
    @(negedge clk);
    drive(32'h900, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("hold_rvalid", 32'(redir_valid), 32'd1);
    chk("hold_qsize", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) chk("hold_rpc", redir_pc, exp_q.pop_front());
    @(negedge clk);
    chk("hold_rpc_c2", redir_pc, 32'h880);
    chk("hold_busy_c2", 32'(inst_ready), 32'd0);
    chk("hold_count_c2", 32'(ras_count), 32'(mstack.size()));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle_inputs();
    mstack.delete();
    chk("flush_rvalid", 32'(redir_valid), 32'd0);
    chk("flush_count", 32'(ras_count), 32'd0);

    // Flush discards a same-cycle instruction
    @(negedge clk);
    drive(32'hA00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA80);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle_inputs();
    chk("flush_inst_rvalid", 32'(redir_valid), 32'd0);
    chk("flush_inst_count", 32'(ras_count), 32'd0);

    // Asynchronous reset while holding a redirect
    send("rst_call", 32'hB00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(32'hC00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC40);
    @(negedge clk);
    idle_inputs();
    chk("arst_hold", 32'(redir_valid), 32'd1);
    chk("arst_hold_rpc", redir_pc, 32'hC40);
    #2 rst = 1'b1;
    #1;
    chk("arst_rvalid", 32'(redir_valid), 32'd0);
    chk("arst_count", 32'(ras_count), 32'd0);
    chk("arst_rpc", redir_pc, 32'd0);
    chk("arst_ready", 32'(inst_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mstack.delete();

    send("post_rst_jal", 32'hD00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hD80);
    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
